// File: rtl/mult_64bit_seq_if.sv
// Operand/result handshake bundle for the iterative 64x64 multiplier.
interface mult_64bit_seq_if;
   localparam int unsigned OP_W  = 64;
   localparam int unsigned RES_W = 128;

   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  a_i;
   logic [OP_W-1:0]  b_i;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] p_o;

   // Source/sink side driving operands and consuming the result
   modport master (
      output in_valid, a_i, b_i, out_ready,
      input  in_ready, out_valid, p_o
   );

   // Multiplier side accepting operands and presenting the result
   modport slave (
      input  in_valid, a_i, b_i, out_ready,
      output in_ready, out_valid, p_o
   );
endinterface

// File: rtl/mult_64bit_seq.sv
// Iterative 64x64 unsigned multiplier built from four 32x32 sub-products
// issued to an external multiplier with 0 or 1 cycle of latency.
module mult_64bit_seq #(
   parameter int unsigned MULT_LAT = 0
) (
   input  logic                CLK,
   input  logic                RST_N,
   mult_64bit_seq_if.slave     bus,
   output logic [31:0]         mul_a_o,
   output logic [31:0]         mul_b_o,
   input  logic [63:0]         mul_p_i,
   output logic                busy_o
);
   localparam int unsigned HALF_W = 32;
   localparam int unsigned OP_W   = 64;
   localparam int unsigned RES_W  = 128;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state;
   state_t             state_next;
   logic [OP_W-1:0]    a_q;
   logic [OP_W-1:0]    b_q;
   logic [1:0]         k;
   logic               pend_vld;
   logic [1:0]         pend_k;
   logic [RES_W-1:0]   acc;
   logic [RES_W-1:0]   acc_next;
   logic [RES_W-1:0]   addend;
   logic               add_vld;
   logic [1:0]         add_k;
   logic               accept;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;
   logic [RES_W-1:0]   p_q;

   assign accept        = (state == IDLE) && bus.in_valid;
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.p_o       = p_q;
   assign busy_o        = busy_q;

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = ISSUE;
         ISSUE:   if (k == 2'd3) state_next = (MULT_LAT == 0) ? DONE : DRAIN;
         DRAIN:   state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Sub-product operand select and accumulator update
   always_comb begin
      mul_a_o = '0;
      mul_b_o = '0;
      if (state == ISSUE) begin
         case (k)
            2'd0:    begin mul_a_o = a_q[HALF_W-1:0];    mul_b_o = b_q[HALF_W-1:0];    end
            2'd1:    begin mul_a_o = a_q[OP_W-1:HALF_W]; mul_b_o = b_q[HALF_W-1:0];    end
            2'd2:    begin mul_a_o = a_q[HALF_W-1:0];    mul_b_o = b_q[OP_W-1:HALF_W]; end
            default: begin mul_a_o = a_q[OP_W-1:HALF_W]; mul_b_o = b_q[OP_W-1:HALF_W]; end
         endcase
      end

      // The returned product belongs to the index issued MULT_LAT cycles ago
      if (MULT_LAT == 0) begin
         add_vld = (state == ISSUE);
         add_k   = k;
      end else begin
         add_vld = pend_vld;
         add_k   = pend_k;
      end

      case (add_k)
         2'd0:    addend = {64'd0, mul_p_i};
         2'd3:    addend = {mul_p_i, 64'd0};
         default: addend = {32'd0, mul_p_i, 32'd0};
      endcase

      acc_next = add_vld ? (acc + addend) : acc;
   end

   // Operand capture, issue index, in-flight tracking and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         a_q         <= '0;
         b_q         <= '0;
         k           <= '0;
         pend_vld    <= 1'b0;
         pend_k      <= '0;
         acc         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         p_q         <= '0;
      end else begin
         if (accept) begin
            a_q <= bus.a_i;
            b_q <= bus.b_i;
            acc <= '0;
            k   <= '0;
         end else begin
            acc <= acc_next;
            if (state == ISSUE) k <= k + 2'd1;
         end
         pend_vld    <= (state == ISSUE);
         pend_k      <= k;
         in_ready_q  <= (state_next == IDLE);
         out_valid_q <= (state_next == DONE);
         busy_q      <= (state_next != IDLE);
         p_q         <= (state_next == DONE) ? acc_next : '0;
      end
   end
endmodule

// File: tb/tb_mult_64bit_seq.sv
// Directed and random checks of mult_64bit_seq with both multiplier latencies.
module tb_mult_64bit_seq;
   logic        CLK;
   logic        RST_N;
   logic [31:0] mul_a0, mul_b0, mul_a1, mul_b1;
   logic [63:0] mul_p0, mul_p1;
   logic        busy0, busy1;
   int          n_checks;
   int          n_errors;
   logic [31:0] seq_a [4];
   logic [31:0] seq_b [4];

   mult_64bit_seq_if bus0 ();
   mult_64bit_seq_if bus1 ();

   mult_64bit_seq #(.MULT_LAT(0)) u_dut0 (
      .CLK(CLK), .RST_N(RST_N), .bus(bus0),
      .mul_a_o(mul_a0), .mul_b_o(mul_b0), .mul_p_i(mul_p0), .busy_o(busy0)
   );

   mult_64bit_seq #(.MULT_LAT(1)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .bus(bus1),
      .mul_a_o(mul_a1), .mul_b_o(mul_b1), .mul_p_i(mul_p1), .busy_o(busy1)
   );

   // External 32x32 multipliers: combinational and registered
   assign mul_p0 = {32'd0, mul_a0} * {32'd0, mul_b0};
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) mul_p1 <= '0;
      else        mul_p1 <= {32'd0, mul_a1} * {32'd0, mul_b1};
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [63:0] a, input logic [63:0] b);
      if (sel) begin bus1.in_valid = v; bus1.a_i = a; bus1.b_i = b; end
      else     begin bus0.in_valid = v; bus0.a_i = a; bus0.b_i = b; end
   endtask

   task automatic set_ordy(input bit sel, input logic v);
      if (sel) bus1.out_ready = v;
      else     bus0.out_ready = v;
   endtask

   function automatic logic get_ir(input bit sel);
      return sel ? bus1.in_ready : bus0.in_ready;
   endfunction

   function automatic logic get_ov(input bit sel);
      return sel ? bus1.out_valid : bus0.out_valid;
   endfunction

   function automatic logic [127:0] get_p(input bit sel);
      return sel ? bus1.p_o : bus0.p_o;
   endfunction

   function automatic logic [2:0] get_flags(input bit sel);
      return sel ? {bus1.out_valid, bus1.in_ready, busy1} : {bus0.out_valid, bus0.in_ready, busy0};
   endfunction

   // One job: offer operands, time the result, optionally stall, then retire it
   task automatic run_job(input bit sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input int hold, input bit early_rdy,
                          input string tag);
      int cnt;
      int lat_exp;
      logic [127:0] p_first;
      lat_exp = sel ? 6 : 5;
      set_ordy(sel, early_rdy);
      set_in(sel, 1'b1, a, b);
      cnt = 0;
      while (!get_ir(sel) && cnt < 20) begin @(negedge CLK); cnt++; end
      check({tag, " in_ready"}, 128'(get_ir(sel)), 128'd1);
      if (!get_ir(sel)) begin set_in(sel, 1'b0, a, b); return; end
      @(negedge CLK);
      set_in(sel, 1'b0, ~a, ~b);
      cnt = 1;
      while (!get_ov(sel) && cnt < 20) begin
         if (cnt <= 4) begin
            seq_a[cnt-1] = sel ? mul_a1 : mul_a0;
            seq_b[cnt-1] = sel ? mul_b1 : mul_b0;
         end
         @(negedge CLK);
         cnt++;
      end
      check({tag, " latency"}, 128'(cnt), 128'(lat_exp));
      if (!get_ov(sel)) begin set_ordy(sel, 1'b0); return; end
      check({tag, " p_o"}, get_p(sel), exp);
      p_first = get_p(sel);
      if (!early_rdy) begin
         for (int i = 0; i < hold; i++) begin
            if (i == 0) set_in(sel, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
            else        set_in(sel, 1'b0, 64'd0, 64'd0);
            @(negedge CLK);
            check({tag, " hold p_o"}, get_p(sel), p_first);
            check({tag, " hold flags"}, 128'(get_flags(sel)), 128'(3'b101));
         end
         set_in(sel, 1'b0, 64'd0, 64'd0);
         set_ordy(sel, 1'b1);
      end
      @(negedge CLK);
      set_ordy(sel, 1'b0);
      check({tag, " retire flags"}, 128'(get_flags(sel)), 128'(3'b010));
   endtask

   initial begin
      logic [31:0]  ea [4];
      logic [31:0]  eb [4];
      logic [63:0]  ra, rb;
      logic [127:0] rexp;
      bit           sel;
      n_checks = 0;
      n_errors = 0;
      ea = '{32'd2, 32'd1, 32'd2, 32'd1};
      eb = '{32'd4, 32'd4, 32'd3, 32'd3};
      RST_N = 1'b0;
      set_in(1'b0, 1'b0, 64'd0, 64'd0);
      set_in(1'b1, 1'b0, 64'd0, 64'd0);
      set_ordy(1'b0, 1'b0);
      set_ordy(1'b1, 1'b0);
      repeat (3) @(negedge CLK);
      check("reset flags0", 128'(get_flags(1'b0)), 128'(3'b010));
      check("reset flags1", 128'(get_flags(1'b1)), 128'(3'b010));
      check("reset p_o0", get_p(1'b0), 128'd0);
      check("reset mul_a0", 128'({mul_a0, mul_b0}), 128'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      // Basic vector, both latencies, with issue order check
      run_job(1'b0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
              128'h0000_0000_0000_0003_0000_000A_0000_0008, 0, 1'b0, "basic0");
      for (int i = 0; i < 4; i++) check($sformatf("seq0[%0d]", i), 128'({seq_a[i], seq_b[i]}), 128'({ea[i], eb[i]}));
      run_job(1'b1, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
              128'h0000_0000_0000_0003_0000_000A_0000_0008, 0, 1'b0, "basic1");
      for (int i = 0; i < 4; i++) check($sformatf("seq1[%0d]", i), 128'({seq_a[i], seq_b[i]}), 128'({ea[i], eb[i]}));

      // Carry-heavy and edge operands
      run_job(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, 1'b0, "max0");
      run_job(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 0, 1'b0, "max1");
      run_job(1'b0, 64'd0, 64'd123, 128'd0, 0, 1'b0, "zero0");
      run_job(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
              128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 0, 1'b1, "x2_1");
      run_job(1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
              128'h0000_0000_0000_0001_0000_0000_0000_0000, 0, 1'b1, "pow64");

      // Backpressure: 10 stalled cycles with a stray in_valid pulse
      run_job(1'b0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
              128'h0000_0000_0000_0003_0000_000A_0000_0008, 10, 1'b0, "bp0");
      run_job(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 10, 1'b0, "bp1");

      // Reset in the middle of ISSUE
      set_in(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge CLK);
      set_in(1'b0, 1'b0, 64'd0, 64'd0);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check("midrst flags", 128'(get_flags(1'b0)), 128'(3'b010));
      check("midrst p_o", get_p(1'b0), 128'd0);
      check("midrst mul", 128'({mul_a0, mul_b0}), 128'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      run_job(1'b0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
              128'h0000_0000_0000_0003_0000_000A_0000_0008, 0, 1'b0, "postrst");

      // Random operands with random result stalls
      for (int j = 0; j < 200; j++) begin
         sel  = 1'($urandom_range(0, 1));
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rexp = {64'd0, ra} * {64'd0, rb};
         run_job(sel, ra, rb, rexp, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 $sformatf("rnd%0d", j));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
